fifo_stream_reader: RTL and testbench

Consumer end of the design's show-ahead FIFOs. Pops words from a FIFO's read port and presents them as a valid/ready stream with packet framing (`out_last` every `PKT_LEN` beats). A two-entry output buffer keeps `fifo_read` free of any combinational dependence on `out_ready`. Sits between a buffering FIFO and any stream sink, e.g. the video/pixel path.

---
 rtl/fifo_stream_reader.sv | 157 +++++++++++++++
 tb/tb_fifo_stream_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: consumer end of a show-ahead FIFO.
// Pops FIFO words into a two-entry output buffer (head + skid) and presents
// them as a valid/ready stream with out_last every PKT_LEN accepted beats.
// fifo_read depends only on registered state, registered occupancy and
// fifo_empty, so it never has a combinational path from out_ready.
// Optional statistics outputs (beat_count, drop_count) are compiled in when
// the macro FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic                  enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
`ifdef FIFO_STREAM_READER_STATS_EN
  output logic [31:0]           beat_count,
  output logic [15:0]           drop_count,
`endif
  output logic                  busy
);

  localparam int unsigned    CNT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                state;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;
  logic [CNT_W-1:0]      pkt_cnt;

  logic                  accept;
  logic                  buf_pop;
  logic [1:0]            occ_acc;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] skid_next;

  // Stream outputs are pure functions of the registered buffer and counter.
  assign out_valid = (occ != 2'd0);
  assign out_data  = head;
  assign out_last  = out_valid && (pkt_cnt == CNT_LAST);
  assign busy      = (state != ST_IDLE) || out_valid;

  // Pop strobe, handshake decode and next buffer contents.
  // The accept is applied first (skid slides to head), then the popped word
  // lands in the first entry left free, which keeps word order intact.
  always_comb begin
    fifo_read = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_FLUSH)
        fifo_read = 1'b1;
      else if (state == ST_RUN && occ != 2'd2)
        fifo_read = 1'b1;
    end

    accept    = out_valid && out_ready;
    buf_pop   = fifo_read && (state == ST_RUN);
    occ_acc   = occ - {1'b0, accept};
    occ_next  = occ_acc + {1'b0, buf_pop};

    head_next = head;
    skid_next = skid;
    if (accept)
      head_next = skid;
    if (buf_pop) begin
      if (occ_acc == 2'd0)
        head_next = fifo_rdata;
      else
        skid_next = fifo_rdata;
    end
  end

  // Control FSM: flush has top priority, then flush drain, then enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (flush) begin
      state <= ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: if (fifo_empty) state <= ST_IDLE;
        ST_IDLE:  if (enable)     state <= ST_RUN;
        ST_RUN:   if (!enable)    state <= ST_IDLE;
        default:                  state <= ST_IDLE;
      endcase
    end
  end

  // Output buffer: flush discards everything held, including a word popped
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      occ  <= 2'd0;
    end else begin
      occ  <= occ_next;
      head <= head_next;
      skid <= skid_next;
    end
  end

  // Packet position counter; survives RUN<->IDLE so a paused packet resumes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pkt_cnt <= '0;
    end else if (accept) begin
      if (pkt_cnt == CNT_LAST)
        pkt_cnt <= '0;
      else
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [1:0]  drop_now;
  logic [16:0] drop_sum;

  // Words lost this cycle: pops while draining, plus whatever the buffer
  // would have held after this cycle's update when flush is sampled.
  always_comb begin
    drop_now = {1'b0, (state == ST_FLUSH) && fifo_read};
    if (flush)
      drop_now = drop_now + occ_next;
    drop_sum = {1'b0, drop_count} + 17'(drop_now);
  end

  // Statistics counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
      drop_count <= '0;
    end else begin
      if (accept)
        beat_count <= beat_count + 32'd1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with PKT_LEN=4.
// A small show-ahead FIFO model feeds the DUT; outputs are sampled 1 time
// unit after each rising edge and compared against hand-computed values.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_read;
  logic       enable;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] beat_count;
  logic [15:0] drop_count;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Show-ahead FIFO model: wr advanced by the stimulus, rd by pops.
  logic [7:0] mem [256];
  logic [7:0] wr = 8'd0;
  logic [7:0] rd = 8'd0;
  logic [7:0] base;

  assign fifo_empty = (rd == wr);
  assign fifo_rdata = mem[rd];

  always @(posedge clk)
    if (fifo_read && !fifo_empty) rd <= rd + 8'd1;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .PKT_LEN    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .enable     (enable),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
`ifdef FIFO_STREAM_READER_STATS_EN
    .beat_count (beat_count),
    .drop_count (drop_count),
`endif
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr] = v;
    wr = wr + 8'd1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Expect consecutive accepted beats lo..hi; with PKT_LEN=4 and packets
  // aligned to multiples of 4, the last beat is every value ending in 2'b11.
  task automatic stream_expect(input int unsigned lo, input int unsigned hi);
    logic [7:0] ev;
    for (int unsigned v = lo; v <= hi; v++) begin
      ev = 8'(v);
      chk1("stream_valid", out_valid, 1'b1);
      chk8("stream_data", out_data, ev);
      chk1("stream_last", out_last, ev[1:0] == 2'b11);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; flush = 1'b0; out_ready = 1'b1;

    // Reset with words waiting in the FIFO.
    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rst_read",  fifo_read, 1'b0);
      chk1("rst_valid", out_valid, 1'b0);
      chk1("rst_last",  out_last,  1'b0);
      chk1("rst_busy",  busy,      1'b0);
      chk8("rst_data",  out_data,  8'h00);
    end
    rst = 1'b0; enable = 1'b0;
    wr = rd;
    tick();
    chk1("idle_busy", busy, 1'b0);

    // Streaming: 8 beats, one per cycle.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    enable = 1'b1;
    base = rd;
    tick();
    chk1("run_first_read", fifo_read, 1'b1);
    chk1("run_no_valid_yet", out_valid, 1'b0);
    tick();
    stream_expect(32'h10, 32'h17);
    chk1("stream_done_valid", out_valid, 1'b0);
    chk1("stream_done_read", fifo_read, 1'b0);
    chk8("stream_pops", rd - base, 8'd8);

    // Backpressure: out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    base = rd;
    tick();
    chk8("bp_d0", out_data, 8'h20);
    tick();
    chk8("bp_d1", out_data, 8'h21);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk8("bp_hold_data", out_data, 8'h21);
      chk1("bp_hold_last", out_last, 1'b0);
      chk1("bp_no_read", fifo_read, 1'b0);
    end
    chk8("bp_pops", rd - base, 8'd3);
    out_ready = 1'b1;
    tick();
    stream_expect(32'h22, 32'h27);
    chk1("bp_done_valid", out_valid, 1'b0);
    chk8("bp_total_pops", rd - base, 8'd8);

    // Pause after 2 beats, resume, packet position preserved.
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    tick();
    chk8("pause_d0", out_data, 8'h30);
    tick();
    chk8("pause_d1", out_data, 8'h31);
    enable = 1'b0;
    tick();
    chk8("pause_buffered", out_data, 8'h32);
    chk1("pause_buf_last", out_last, 1'b0);
    chk1("pause_no_read", fifo_read, 1'b0);
    tick();
    chk1("pause_drained", out_valid, 1'b0);
    chk1("pause_idle_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("pause_wait_read", fifo_read, 1'b0);
      chk1("pause_wait_valid", out_valid, 1'b0);
    end
    enable = 1'b1;
    tick();
    chk1("resume_read", fifo_read, 1'b1);
    tick();
    stream_expect(32'h33, 32'h37);
    chk1("resume_done_valid", out_valid, 1'b0);

    // Flush with 2 buffered words and 3 left in the FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    tick();
    tick();
    chk8("fl_head", out_data, 8'h40);
    chk1("fl_full_no_read", fifo_read, 1'b0);
    flush = 1'b1;
`ifdef FIFO_STREAM_READER_STATS_EN
    base = drop_count[7:0];
`endif
    tick();
    flush = 1'b0;
    chk1("fl_valid", out_valid, 1'b0);
    chk1("fl_last", out_last, 1'b0);
    chk1("fl_read", fifo_read, 1'b1);
    chk1("fl_busy", busy, 1'b1);
    tick();
    tick();
    chk1("fl_read2", fifo_read, 1'b1);
    tick();
    chk1("fl_empty_read", fifo_read, 1'b0);
    chk1("fl_drain_valid", out_valid, 1'b0);
    chk1("fl_drain_busy", busy, 1'b1);
    chk8("fl_fifo_level", wr - rd, 8'd0);
    tick();
    chk1("fl_idle_busy", busy, 1'b0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk8("fl_drop_count", drop_count[7:0] - base, 8'd5);
`endif
    tick();
    chk1("fl_rerun_busy", busy, 1'b1);

    // Flush and enable together: flush wins, counter restarts.
    out_ready = 1'b1;
    push(8'h50); push(8'h51);
    tick();
    chk8("fe_d0", out_data, 8'h50);
    tick();
    chk8("fe_d1", out_data, 8'h51);
    tick();
    chk1("fe_idle_valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("fe_no_beat", out_valid, 1'b0);
      chk1("fe_read", fifo_read, 1'b1);
    end
    flush = 1'b0;
    tick();
    chk1("fe_drained_valid", out_valid, 1'b0);
    chk1("fe_drained_read", fifo_read, 1'b0);
    tick();
    chk1("fe_idle_busy", busy, 1'b0);
    tick();
    chk1("fe_run_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
    tick();
    stream_expect(32'h70, 32'h73);
    chk1("fe_done_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
